sec_timer_ctrl: RTL and testbench

SEC_TIMER_CTRL -- requirements
Module: sec_timer_ctrl

---
 rtl/sec_timer_ctrl.sv | 113 +++++++++++
 tb/tb_sec_timer_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_timer_ctrl.sv
// Two-digit BCD seconds countdown (59..00) with prescaled tick, pause/resume,
// preset load with range checking, and registered status pulses.
module sec_timer_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_units,
  input  logic [2:0] load_tens,
  output logic [3:0] units,
  output logic [2:0] tens,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

  logic [1:0] state, state_nx;
  logic [7:0] presc, presc_nx;
  logic [3:0] units_nx;
  logic [2:0] tens_nx;
  logic       done_nx;
  logic       load_err_nx;
  logic       load_bad;
  logic       count_zero;

  assign load_bad   = (load_units > 4'd9) || (load_tens > 3'd5);
  assign count_zero = (units == 4'd0) && (tens == 3'd0);

  // Commands are mutually exclusive in priority order; a tick only counts when
  // no command that discards it (clear, load, stop, effective start) is active.
  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    units_nx    = units;
    tens_nx     = tens;
    done_nx     = 1'b0;
    load_err_nx = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
      presc_nx = '0;
      units_nx = '0;
      tens_nx  = '0;
    end else if (load) begin
      if (state == S_RUN || load_bad) begin
        load_err_nx = 1'b1;
      end else begin
        state_nx = S_IDLE;
        presc_nx = '0;
        units_nx = load_units;
        tens_nx  = load_tens;
      end
    end else if (stop) begin
      if (state == S_RUN)
        state_nx = S_PAUSE;
    end else if (start && (state == S_IDLE || state == S_PAUSE)) begin
      if (count_zero) begin
        state_nx = S_DONE;
        done_nx  = 1'b1;
      end else begin
        state_nx = S_RUN;
      end
    end else if (state == S_RUN && tick) begin
      if (presc == PRESC_MAX) begin
        presc_nx = '0;
        if (units != 4'd0) begin
          units_nx = units - 4'd1;
        end else begin
          units_nx = 4'd9;
          tens_nx  = tens - 3'd1;
        end
        if (tens == 3'd0 && units == 4'd1) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end
      end else begin
        presc_nx = presc + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      presc    <= '0;
      units    <= '0;
      tens     <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      units    <= units_nx;
      tens     <= tens_nx;
      running  <= (state_nx == S_RUN);
      done     <= done_nx;
      load_err <= load_err_nx;
    end
  end

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// Bench for sec_timer_ctrl: two instances (TICK_DIV 1 and 3) driven in parallel,
// checked every cycle against a seconds-count model plus directed literal checks.
module tb_sec_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, start, stop, clear, load;
  logic [3:0] load_units;
  logic [2:0] load_tens;

  logic [3:0] units_o [2];
  logic [2:0] tens_o  [2];
  logic       run_o   [2];
  logic       done_o  [2];
  logic       lerr_o  [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sec_timer_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_units(load_units), .load_tens(load_tens),
    .units(units_o[0]), .tens(tens_o[0]), .running(run_o[0]),
    .done(done_o[0]), .load_err(lerr_o[0])
  );

  sec_timer_ctrl #(.TICK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_units(load_units), .load_tens(load_tens),
    .units(units_o[1]), .tens(tens_o[1]), .running(run_o[1]),
    .done(done_o[1]), .load_err(lerr_o[1])
  );

  // Model: the count is a plain number of seconds, stepped down by one.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  int    div    [2] = '{1, 3};
  int    m_cnt  [2] = '{0, 0};
  int    m_pre  [2] = '{0, 0};
  mode_t m_mode [2] = '{M_IDLE, M_IDLE};
  bit    m_done [2] = '{0, 0};
  bit    m_lerr [2] = '{0, 0};

  function automatic void model_step(int i, bit in_reset);
    m_done[i] = 1'b0;
    m_lerr[i] = 1'b0;
    if (in_reset) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_mode[i] = M_IDLE;
    end else if (clear) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_mode[i] = M_IDLE;
    end else if (load) begin
      if (m_mode[i] == M_RUN || int'(load_units) > 9 || int'(load_tens) > 5)
        m_lerr[i] = 1'b1;
      else begin
        m_cnt[i]  = int'(load_tens) * 10 + int'(load_units);
        m_pre[i]  = 0;
        m_mode[i] = M_IDLE;
      end
    end else if (stop) begin
      if (m_mode[i] == M_RUN) m_mode[i] = M_PAUSE;
    end else if (start && (m_mode[i] == M_IDLE || m_mode[i] == M_PAUSE)) begin
      if (m_cnt[i] == 0) begin
        m_mode[i] = M_DONE; m_done[i] = 1'b1;
      end else m_mode[i] = M_RUN;
    end else if (tick && m_mode[i] == M_RUN) begin
      m_pre[i]++;
      if (m_pre[i] == div[i]) begin
        m_pre[i] = 0;
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_mode[i] = M_DONE; m_done[i] = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) model_step(i, !reset);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("units[%0d]", i), 8'(units_o[i]), 8'(m_cnt[i] % 10));
        chk($sformatf("tens[%0d]", i), 8'(tens_o[i]), 8'(m_cnt[i] / 10));
        chk($sformatf("running[%0d]", i), 8'(run_o[i]), 8'(m_mode[i] == M_RUN));
        chk($sformatf("done[%0d]", i), 8'(done_o[i]), 8'(m_done[i]));
        chk($sformatf("load_err[%0d]", i), 8'(lerr_o[i]), 8'(m_lerr[i]));
      end
    end
  end

  task automatic cmd(input bit c, input bit l, input bit s, input bit st, input bit t,
                     input logic [3:0] lu, input logic [2:0] lt);
    clear = c; load = l; stop = s; start = st; tick = t;
    load_units = lu; load_tens = lt;
    @(posedge clk); #1;
    clear = 0; load = 0; stop = 0; start = 0; tick = 0;
  endtask

  task automatic idle();               cmd(0, 0, 0, 0, 0, 4'd0, 3'd0); endtask
  task automatic do_clear();           cmd(1, 0, 0, 0, 0, 4'd0, 3'd0); endtask
  task automatic do_start();           cmd(0, 0, 0, 1, 0, 4'd0, 3'd0); endtask
  task automatic do_tick();            cmd(0, 0, 0, 0, 1, 4'd0, 3'd0); endtask
  task automatic do_stop_tick();       cmd(0, 0, 1, 0, 1, 4'd0, 3'd0); endtask
  task automatic do_load(input logic [3:0] u, input logic [2:0] t);
    cmd(0, 1, 0, 0, 0, u, t);
  endtask

  task automatic chk_cnt(input string name, input int i, input int secs);
    chk({name, ".units"}, 8'(units_o[i]), 8'(secs % 10));
    chk({name, ".tens"}, 8'(tens_o[i]), 8'(secs / 10));
  endtask

  initial begin
    reset = 1'b0;
    tick = 0; start = 0; stop = 0; clear = 0; load = 0;
    load_units = '0; load_tens = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt("reset", 0, 0);
    chk("reset.running", 8'(run_o[0]), 8'd0);
    chk("reset.done", 8'(done_o[0]), 8'd0);
    chk("reset.load_err", 8'(lerr_o[0]), 8'd0);
    reset = 1'b1;
    cmp_en = 1'b1;
    idle();

    // 25 s countdown, TICK_DIV=1
    do_clear();
    do_load(4'd5, 3'd2);
    chk_cnt("load25", 0, 25);
    do_start();
    chk("start25.running", 8'(run_o[0]), 8'd1);
    for (int k = 24; k >= 0; k--) begin
      do_tick();
      chk_cnt($sformatf("cd25_%0d", k), 0, k);
      chk("cd25.done", 8'(done_o[0]), 8'(k == 0));
    end
    chk("cd25.end_running", 8'(run_o[0]), 8'd0);
    do_tick();
    chk("cd25.done_once", 8'(done_o[0]), 8'd0);
    chk_cnt("cd25.hold", 0, 0);

    // Borrow across the digit boundary
    do_clear();
    do_load(4'd0, 3'd1);
    do_start();
    do_tick();
    chk_cnt("borrow", 0, 9);

    // Rejected loads
    do_clear();
    do_load(4'd4, 3'd3);
    do_load(4'd10, 3'd1);
    chk("lerr_units", 8'(lerr_o[0]), 8'd1);
    chk_cnt("lerr_units", 0, 34);
    idle();
    chk("lerr_pulse", 8'(lerr_o[0]), 8'd0);
    do_load(4'd2, 3'd6);
    chk("lerr_tens", 8'(lerr_o[0]), 8'd1);
    chk_cnt("lerr_tens", 0, 34);
    do_start();
    do_load(4'd1, 3'd1);
    chk("lerr_run", 8'(lerr_o[0]), 8'd1);
    chk_cnt("lerr_run", 0, 34);
    chk("lerr_run.running", 8'(run_o[0]), 8'd1);

    // Prescaler TICK_DIV=3
    do_clear();
    do_load(4'd0, 3'd3);
    do_start();
    do_tick();
    do_tick();
    chk_cnt("div3_2ticks", 1, 30);
    do_tick();
    chk_cnt("div3_3ticks", 1, 29);
    chk_cnt("div1_3ticks", 0, 27);

    // Stop coinciding with tick
    do_stop_tick();
    chk_cnt("stop_tick", 0, 27);
    chk("stop_tick.running", 8'(run_o[0]), 8'd0);
    do_tick();
    chk_cnt("pause_tick", 0, 27);
    do_start();
    chk("resume.running", 8'(run_o[0]), 8'd1);
    do_tick();
    chk_cnt("resume_tick", 0, 26);

    // Asynchronous reset mid-run, then start from 00
    do_clear();
    do_load(4'd7, 3'd3);
    do_start();
    do_tick();
    do_tick();
    do_tick();
    #2 reset = 1'b0;
    #1;
    chk_cnt("async_rst", 0, 0);
    chk("async_rst.running", 8'(run_o[0]), 8'd0);
    chk("async_rst.done", 8'(done_o[0]), 8'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.done", 8'(done_o[0]), 8'd0);
    do_start();
    chk("start00.done", 8'(done_o[0]), 8'd1);
    chk("start00.running", 8'(run_o[0]), 8'd0);
    idle();
    chk("start00.done_once", 8'(done_o[0]), 8'd0);

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] lu;
      logic [2:0] lt;
      bit c, l, s, st, t;
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 7);
      s  = ($urandom_range(0, 99) < 5);
      st = ($urandom_range(0, 99) < 12);
      t  = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 9) < 8) begin
        lu = 4'($urandom_range(0, 9));
        lt = 3'($urandom_range(0, 1));
      end else begin
        lu = 4'($urandom_range(0, 15));
        lt = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
      cmd(c, l, s, st, t, lu, lt);
    end

    idle();
    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
